// File: rtl/ofdm_sync_ctrl_pkg.sv
// Shared encodings for the OFDM sync sequencer: FSM states, controller
// register offsets and control-word bit positions.
package ofdm_sync_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_FRAME   = 3'd3,
        ST_TAIL    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    localparam int REG_CTRL_OFF    = 0;
    localparam int REG_TIMEOUT_OFF = 1;
    localparam int REG_HOLDOFF_OFF = 2;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_SOFT_CLEAR_BIT = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ofdm_sync_ctrl_shadow.sv
// Shadow register bank: holds host datapath settings and forwards the
// lowest-index dirty entry, one per cycle, while i_allow is high.
module settings_shadow_bank #(
    parameter int NUM_SHADOW = 7,
    parameter int AW         = 8,
    parameter int DW         = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_stb,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_allow,
    output logic          o_stb,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_pending
);
    localparam int IW = (NUM_SHADOW > 1) ? $clog2(NUM_SHADOW) : 1;

    logic [DW-1:0]         r_shadow [NUM_SHADOW];
    logic [NUM_SHADOW-1:0] r_dirty;
    logic                  r_stb;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_data;

    logic [NUM_SHADOW-1:0] w_wr_hit;
    logic [NUM_SHADOW-1:0] w_avail;
    logic [NUM_SHADOW-1:0] w_dirty_nxt;
    logic                  w_sel_vld;
    logic [IW-1:0]         w_sel_idx;
    logic [DW-1:0]         w_sel_data;
    logic                  w_fwd;

    always_comb begin
        for (int i = 0; i < NUM_SHADOW; i++)
            w_wr_hit[i] = i_wr_stb && (i_wr_addr == AW'(i));
    end

    // An incoming write is visible to the selector this cycle so a clean
    // entry goes out with one cycle of latency.
    assign w_avail = r_dirty | w_wr_hit;

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int i = NUM_SHADOW - 1; i >= 0; i--) begin
            if (w_avail[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    assign w_sel_data = r_dirty[w_sel_idx] ? r_shadow[w_sel_idx] : i_wr_data;
    assign w_fwd      = i_allow && w_sel_vld;

    // Old value leaving while a new one lands keeps the bit set for a re-send.
    always_comb begin
        w_dirty_nxt = r_dirty | w_wr_hit;
        if (w_fwd && !(r_dirty[w_sel_idx] && w_wr_hit[w_sel_idx]))
            w_dirty_nxt[w_sel_idx] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_SHADOW; i++)
                r_shadow[i] <= '0;
            r_dirty <= '0;
            r_stb   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_SHADOW; i++)
                if (w_wr_hit[i])
                    r_shadow[i] <= i_wr_data;
            r_dirty <= w_dirty_nxt;
            r_stb   <= w_fwd;
            if (w_fwd) begin
                r_addr <= AW'(w_sel_idx);
                r_data <= w_sel_data;
            end
        end
    end

    assign o_stb     = r_stb;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_pending = |r_dirty;

endmodule

// File: rtl/ofdm_sync_ctrl.sv
// Schmidl-Cox sync chain sequencer: frame lifecycle FSM, watchdog flush,
// post-frame holdoff, and between-frame forwarding of shadowed settings.
module ofdm_sync_ctrl
    import ofdm_sync_ctrl_pkg::*;
#(
    parameter int NUM_SHADOW   = 7,
    parameter int SR_CTRL_BASE = 8,
    parameter int TIMEOUT_W    = 24,
    parameter int HOLDOFF_W    = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_set_stb,
    input  logic [7:0]  i_set_addr,
    input  logic [31:0] i_set_data,
    output logic        o_dp_set_stb,
    output logic [7:0]  o_dp_set_addr,
    output logic [31:0] o_dp_set_data,
    output logic        o_dp_clear,
    input  logic        i_sof,
    input  logic        i_eof,
    input  logic        i_mon_tvalid,
    input  logic        i_mon_tready,
    input  logic        i_mon_tlast,
    output logic [2:0]  o_state,
    output logic [15:0] o_frame_count,
    output logic [15:0] o_timeout_count,
    output logic        o_pending
);
    localparam int FCW = $clog2(FLUSH_CYCLES) + 1;

    state_t               r_state;
    logic                 r_enable;
    logic                 r_soft_clear;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [HOLDOFF_W-1:0] r_holdoff;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 r_wd_en;
    logic [HOLDOFF_W-1:0] r_ho_cnt;
    logic [FCW-1:0]       r_flush_cnt;
    logic                 r_dp_clear;
    logic [15:0]          r_frame_cnt;
    logic [15:0]          r_timeout_cnt;

    logic w_wr_ctrl, w_wr_timeout, w_wr_holdoff;
    logic w_allow, w_armed, w_wd_exp, w_tlast_hs, w_frame_done;

    assign w_wr_ctrl    = i_set_stb && (i_set_addr == 8'(SR_CTRL_BASE + REG_CTRL_OFF));
    assign w_wr_timeout = i_set_stb && (i_set_addr == 8'(SR_CTRL_BASE + REG_TIMEOUT_OFF));
    assign w_wr_holdoff = i_set_stb && (i_set_addr == 8'(SR_CTRL_BASE + REG_HOLDOFF_OFF));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_enable     <= 1'b0;
            r_soft_clear <= 1'b0;
            r_timeout    <= '0;
            r_holdoff    <= '0;
        end else begin
            r_soft_clear <= w_wr_ctrl && i_set_data[CTRL_SOFT_CLEAR_BIT];
            if (w_wr_ctrl)
                r_enable <= i_set_data[CTRL_ENABLE_BIT];
            if (w_wr_timeout)
                r_timeout <= i_set_data[TIMEOUT_W-1:0];
            if (w_wr_holdoff)
                r_holdoff <= i_set_data[HOLDOFF_W-1:0];
        end
    end

    assign w_allow      = (r_state == ST_SEARCH) || (r_state == ST_HOLDOFF);
    assign w_armed      = (r_state != ST_IDLE) && (r_state != ST_FLUSH);
    assign w_tlast_hs   = i_mon_tvalid && i_mon_tready && i_mon_tlast;
    assign w_wd_exp     = ((r_state == ST_FRAME) || (r_state == ST_TAIL)) && r_wd_en &&
                          (r_wd == TIMEOUT_W'(1));
    assign w_frame_done = w_tlast_hs && ((r_state == ST_TAIL) || (r_state == ST_FRAME && i_eof));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_wd          <= '0;
            r_wd_en       <= 1'b0;
            r_ho_cnt      <= '0;
            r_flush_cnt   <= '0;
            r_dp_clear    <= 1'b0;
            r_frame_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_dp_clear <= 1'b0;
            if ((w_armed && !r_enable) || (r_soft_clear && r_state != ST_IDLE) || w_wd_exp) begin
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                r_dp_clear  <= 1'b1;
                if (w_wd_exp && r_enable && !r_soft_clear)
                    r_timeout_cnt <= sat_inc16(r_timeout_cnt);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_enable) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                            r_dp_clear  <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_flush_cnt == '0) begin
                            r_state <= r_enable ? ST_SEARCH : ST_IDLE;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - FCW'(1);
                            r_dp_clear  <= 1'b1;
                        end
                    end
                    ST_SEARCH: begin
                        if (i_sof) begin
                            r_wd    <= r_timeout;
                            r_wd_en <= |r_timeout;
                            r_state <= i_eof ? ST_TAIL : ST_FRAME;
                        end
                    end
                    ST_FRAME, ST_TAIL: begin
                        if (r_wd_en)
                            r_wd <= r_wd - TIMEOUT_W'(1);
                        if (w_frame_done) begin
                            r_frame_cnt <= sat_inc16(r_frame_cnt);
                            if (r_holdoff != '0) begin
                                r_state  <= ST_HOLDOFF;
                                r_ho_cnt <= r_holdoff;
                            end else begin
                                r_state <= ST_SEARCH;
                            end
                        end else if (r_state == ST_FRAME && i_eof) begin
                            r_state <= ST_TAIL;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_ho_cnt <= HOLDOFF_W'(1))
                            r_state <= ST_SEARCH;
                        else
                            r_ho_cnt <= r_ho_cnt - HOLDOFF_W'(1);
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    settings_shadow_bank #(
        .NUM_SHADOW (NUM_SHADOW),
        .AW         (8),
        .DW         (32)
    ) u_shadow (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_stb  (i_set_stb),
        .i_wr_addr (i_set_addr),
        .i_wr_data (i_set_data),
        .i_allow   (w_allow),
        .o_stb     (o_dp_set_stb),
        .o_addr    (o_dp_set_addr),
        .o_data    (o_dp_set_data),
        .o_pending (o_pending)
    );

    assign o_state         = r_state;
    assign o_dp_clear      = r_dp_clear;
    assign o_frame_count   = r_frame_cnt;
    assign o_timeout_count = r_timeout_cnt;

endmodule
